// File: rtl/vga_pkg.sv
// Shared VGA constants for the Pong video pipeline: resolution, bus widths
// and the colour values used by the drawing stages.
package vga_pkg;

    localparam int H_RES = 1024;
    localparam int V_RES = 768;
    localparam int RGB_W = 12;
    localparam int CNT_W = 11;

    localparam logic [RGB_W-1:0] COLOR_WHITE = 12'hFFF;
    localparam logic [RGB_W-1:0] COLOR_BLACK = 12'h000;

endpackage

// File: rtl/paddle_pos_ctl.sv
// Per-frame paddle position controller. The paddle top line only changes on
// the single cycle where vertical blank rises, so a frame is never torn.
module paddle_pos_ctl
    import vga_pkg::CNT_W;
#(
    parameter int V_RES = vga_pkg::V_RES,
    parameter int PAD_H = 80,
    parameter int STEP  = 4
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             vblnk_in,
    input  logic             mode_ext,
    input  logic [CNT_W-1:0] y_ext,
    input  logic             btn_up,
    input  logic             btn_down,
    output logic [CNT_W-1:0] y_cur_o
);

    localparam logic [CNT_W-1:0] Y_MAX   = CNT_W'(V_RES - PAD_H);
    localparam logic [CNT_W-1:0] Y_INIT  = CNT_W'((V_RES - PAD_H) / 2);
    localparam logic [CNT_W-1:0] STEP_N  = CNT_W'(STEP);
    localparam logic [CNT_W:0]   STEP_W  = (CNT_W+1)'(STEP);

    logic             vblnk_q;
    logic [CNT_W-1:0] y_q;
    logic [CNT_W-1:0] y_d;
    logic             tick;
    logic [CNT_W:0]   downSum;

    // Edge-detect register and current paddle top line.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vblnk_q <= 1'b0;
            y_q     <= Y_INIT;
        end else begin
            vblnk_q <= vblnk_in;
            y_q     <= y_d;
        end
    end

    // Next position: clamp external value or step with saturation, only on the frame tick.
    always_comb begin
        tick    = vblnk_in & ~vblnk_q;
        downSum = {1'b0, y_q} + STEP_W;
        y_d     = y_q;
        if (tick) begin
            if (mode_ext) begin
                y_d = (y_ext > Y_MAX) ? Y_MAX : y_ext;
            end else if (btn_up && !btn_down) begin
                y_d = (y_q < STEP_N) ? '0 : y_q - STEP_N;
            end else if (btn_down && !btn_up) begin
                y_d = (downSum > {1'b0, Y_MAX}) ? Y_MAX : downSum[CNT_W-1:0];
            end
        end
    end

    assign y_cur_o = y_q;

endmodule

// File: rtl/draw_paddle.sv
// Paddle overlay stage: two-cycle registered pipeline that paints a
// rectangle of fixed colour over the incoming video, with the paddle top
// line supplied by the per-frame position controller.
module draw_paddle
    import vga_pkg::CNT_W;
    import vga_pkg::RGB_W;
    import vga_pkg::COLOR_WHITE;
#(
    parameter int               V_RES = vga_pkg::V_RES,
    parameter int               PAD_W = 10,
    parameter int               PAD_H = 80,
    parameter int               PAD_X = 50,
    parameter int               STEP  = 4,
    parameter logic [RGB_W-1:0] COLOR = COLOR_WHITE
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [CNT_W-1:0] hcount_in,
    input  logic [CNT_W-1:0] vcount_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             hblnk_in,
    input  logic             vblnk_in,
    input  logic [RGB_W-1:0] rgb_in,
    input  logic             mode_ext,
    input  logic [CNT_W-1:0] y_ext,
    input  logic             btn_up,
    input  logic             btn_down,
    output logic [CNT_W-1:0] hcount_out,
    output logic [CNT_W-1:0] vcount_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             hblnk_out,
    output logic             vblnk_out,
    output logic [RGB_W-1:0] rgb_out,
    output logic [CNT_W-1:0] y_pos_out
);

    localparam logic [CNT_W-1:0] X_LEFT  = CNT_W'(PAD_X);
    localparam logic [CNT_W-1:0] X_RIGHT = CNT_W'(PAD_X + PAD_W);
    localparam logic [CNT_W:0]   PAD_H_W = (CNT_W+1)'(PAD_H);

    logic [CNT_W-1:0] yCur;
    logic [CNT_W:0]   padBottom;
    logic             hit_d;

    logic             hit_q;
    logic [RGB_W-1:0] rgb_q;
    logic [CNT_W-1:0] hcount_q;
    logic [CNT_W-1:0] vcount_q;
    logic             hsync_q;
    logic             vsync_q;
    logic             hblnk_q;
    logic             vblnk_q;

    paddle_pos_ctl #(
        .V_RES (V_RES),
        .PAD_H (PAD_H),
        .STEP  (STEP)
    ) u_pos_ctl (
        .pclk     (pclk),
        .rst      (rst),
        .vblnk_in (vblnk_in),
        .mode_ext (mode_ext),
        .y_ext    (y_ext),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .y_cur_o  (yCur)
    );

    // Paddle hit test; bottom edge computed one bit wider so it cannot wrap.
    always_comb begin
        padBottom = {1'b0, yCur} + PAD_H_W;
        hit_d     = (hcount_in >= X_LEFT) && (hcount_in < X_RIGHT) &&
                    (vcount_in >= yCur) && ({1'b0, vcount_in} < padBottom) &&
                    !hblnk_in && !vblnk_in;
    end

    // Stage 1: capture hit flag, upstream colour and timing.
    always_ff @(posedge pclk) begin
        if (rst) begin
            hit_q    <= 1'b0;
            rgb_q    <= '0;
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
        end else begin
            hit_q    <= hit_d;
            rgb_q    <= rgb_in;
            hcount_q <= hcount_in;
            vcount_q <= vcount_in;
            hsync_q  <= hsync_in;
            vsync_q  <= vsync_in;
            hblnk_q  <= hblnk_in;
            vblnk_q  <= vblnk_in;
        end
    end

    // Stage 2: composite paddle colour over the delayed pixel.
    always_ff @(posedge pclk) begin
        if (rst) begin
            rgb_out    <= '0;
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
        end else begin
            rgb_out    <= hit_q ? COLOR : rgb_q;
            hcount_out <= hcount_q;
            vcount_out <= vcount_q;
            hsync_out  <= hsync_q;
            vsync_out  <= vsync_q;
            hblnk_out  <= hblnk_q;
            vblnk_out  <= vblnk_q;
        end
    end

    assign y_pos_out = yCur;

endmodule

// File: tb/tb_draw_paddle.sv
// Self-checking bench for draw_paddle: behavioural model of paddle position
// and overlay, compared every cycle, plus literal spot checks.
module tb_draw_paddle;

    logic        pclk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in, vcount_in, y_ext;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic        mode_ext, btn_up, btn_down;
    logic [10:0] hcount_out, vcount_out, y_pos_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } pix_t;

    pix_t stage1M, outM;
    int   yM;
    bit   vPrevM;

    always #5 pclk = ~pclk;

    draw_paddle dut (
        .pclk       (pclk),
        .rst        (rst),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .mode_ext   (mode_ext),
        .y_ext      (y_ext),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out),
        .y_pos_out  (y_pos_out)
    );

    // Position rule applied on a vertical-blank rise.
    function automatic int nextY(int y, bit m, int ye, bit up, bit dn);
        if (m) return (ye > 688) ? 688 : ye;
        if (up && !dn) return (y < 4) ? 0 : y - 4;
        if (dn && !up) return (y + 4 > 688) ? 688 : y + 4;
        return y;
    endfunction

    task automatic checkOutput(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: predict, clock, then compare every output to the model.
    task automatic tickCycle();
        pix_t n;
        bit   inPad;
        inPad = (int'(hcount_in) >= 50) && (int'(hcount_in) < 60) &&
                (int'(vcount_in) >= yM) && (int'(vcount_in) < yM + 80) &&
                !hblnk_in && !vblnk_in;
        n.hc  = hcount_in;
        n.vc  = vcount_in;
        n.hs  = hsync_in;
        n.vs  = vsync_in;
        n.hb  = hblnk_in;
        n.vb  = vblnk_in;
        n.rgb = inPad ? 12'hFFF : rgb_in;
        @(posedge pclk);
        if (rst) begin
            yM      = 344;
            vPrevM  = 1'b0;
            stage1M = '0;
            outM    = '0;
        end else begin
            if (vblnk_in && !vPrevM)
                yM = nextY(yM, mode_ext, int'(y_ext), btn_up, btn_down);
            vPrevM  = vblnk_in;
            outM    = stage1M;
            stage1M = n;
        end
        @(negedge pclk);
        checkOutput("y_pos_out",  int'(y_pos_out),  yM);
        checkOutput("rgb_out",    int'(rgb_out),    int'(outM.rgb));
        checkOutput("hcount_out", int'(hcount_out), int'(outM.hc));
        checkOutput("vcount_out", int'(vcount_out), int'(outM.vc));
        checkOutput("hsync_out",  int'(hsync_out),  int'(outM.hs));
        checkOutput("vsync_out",  int'(vsync_out),  int'(outM.vs));
        checkOutput("hblnk_out",  int'(hblnk_out),  int'(outM.hb));
        checkOutput("vblnk_out",  int'(vblnk_out),  int'(outM.vb));
    endtask

    task automatic randomPixel();
        int v;
        v = yM + int'($urandom_range(0, 100)) - 10;
        if (v < 0) v = 0;
        hcount_in = 11'($urandom_range(40, 70));
        vcount_in = 11'(v);
        hsync_in  = 1'($urandom);
        vsync_in  = 1'($urandom);
        hblnk_in  = ($urandom_range(0, 7) == 0);
        rgb_in    = 12'($urandom);
    endtask

    // Drive one short synthetic frame: active cycles then a blank interval.
    task automatic applyStimulus(int nActive, int nBlank, bit randCtl);
        for (int i = 0; i < nActive; i++) begin
            vblnk_in = 1'b0;
            randomPixel();
            if (randCtl && ($urandom_range(0, 3) == 0)) begin
                mode_ext = 1'($urandom);
                btn_up   = 1'($urandom);
                btn_down = 1'($urandom);
                y_ext    = 11'($urandom_range(0, 800));
            end
            tickCycle();
        end
        for (int i = 0; i < nBlank; i++) begin
            vblnk_in = 1'b1;
            randomPixel();
            tickCycle();
        end
    endtask

    task automatic setPixel(int h, int v, bit vb, logic [11:0] c);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = 1'b0;
        vblnk_in  = vb;
        rgb_in    = c;
        hsync_in  = 1'b0;
        vsync_in  = 1'b0;
    endtask

    // Drive a pixel, then an idle pixel; the first one appears on the outputs.
    task automatic pixelProbe(string name, int h, int v, bit vb, logic [11:0] c, int exp);
        setPixel(h, v, vb, c);
        tickCycle();
        setPixel(0, 0, 1'b0, 12'h000);
        tickCycle();
        checkOutput(name, int'(rgb_out), exp);
    endtask

    initial begin
        rst = 1'b1;
        mode_ext = 1'b0; btn_up = 1'b0; btn_down = 1'b0; y_ext = '0;
        setPixel(0, 0, 1'b0, 12'h000);
        yM = 344; vPrevM = 1'b0; stage1M = '0; outM = '0;

        for (int i = 0; i < 3; i++) tickCycle();
        checkOutput("reset y_pos", int'(y_pos_out), 344);
        checkOutput("reset rgb", int'(rgb_out), 0);
        checkOutput("reset hcount", int'(hcount_out), 0);

        rst = 1'b0;
        for (int i = 0; i < 5; i++) tickCycle();
        checkOutput("no edge y_pos", int'(y_pos_out), 344);

        pixelProbe("hit 50,344", 50, 344, 1'b0, 12'h123, 12'hFFF);
        pixelProbe("miss 49,344", 49, 344, 1'b0, 12'hABC, 12'hABC);
        pixelProbe("miss 60,344", 60, 344, 1'b0, 12'h456, 12'h456);
        pixelProbe("miss 55,424", 55, 424, 1'b0, 12'h789, 12'h789);
        pixelProbe("hit 59,423", 59, 423, 1'b0, 12'h789, 12'hFFF);
        pixelProbe("vblank mask", 55, 350, 1'b1, 12'h321, 12'h321);
        checkOutput("hold on idle tick", int'(y_pos_out), 344);

        btn_down = 1'b1;
        for (int f = 0; f < 10; f++) applyStimulus(6, 2, 1'b0);
        checkOutput("down 10 frames", int'(y_pos_out), 384);
        for (int f = 10; f < 100; f++) applyStimulus(4, 2, 1'b0);
        checkOutput("down saturate", int'(y_pos_out), 688);
        pixelProbe("bottom line 767", 55, 767, 1'b0, 12'h0F0, 12'hFFF);
        btn_down = 1'b0;

        mode_ext = 1'b1; y_ext = 11'd2;
        applyStimulus(4, 2, 1'b0);
        checkOutput("ext to 2", int'(y_pos_out), 2);
        mode_ext = 1'b0; btn_up = 1'b1;
        applyStimulus(4, 2, 1'b0);
        checkOutput("up floor", int'(y_pos_out), 0);
        applyStimulus(4, 2, 1'b0);
        applyStimulus(4, 2, 1'b0);
        checkOutput("up stays 0", int'(y_pos_out), 0);
        btn_down = 1'b1;
        applyStimulus(4, 2, 1'b0);
        checkOutput("both hold", int'(y_pos_out), 0);
        btn_up = 1'b0; btn_down = 1'b0;

        mode_ext = 1'b1; y_ext = 11'd750;
        applyStimulus(4, 2, 1'b0);
        checkOutput("ext clamp", int'(y_pos_out), 688);
        applyStimulus(3, 0, 1'b0);
        y_ext = 11'd100;
        applyStimulus(5, 0, 1'b0);
        checkOutput("ext mid-frame hold", int'(y_pos_out), 688);
        applyStimulus(2, 2, 1'b0);
        checkOutput("ext 100", int'(y_pos_out), 100);

        for (int f = 0; f < 40; f++) begin
            applyStimulus(int'($urandom_range(2, 12)), int'($urandom_range(1, 3)), 1'b1);
            if (f == 20) begin
                rst = 1'b1;
                tickCycle();
                rst = 1'b0;
                checkOutput("mid reset y_pos", int'(y_pos_out), 344);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
